mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: I-cache and D-cache block fills plus D-cache write-through.
// Define MEM_ARB_RR_EN to alternate between data and instruction classes instead of fixed priority.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    output logic        i_grant,
    output logic        d_grant,
    output logic        fill_valid,
    output logic [2:0]  fill_word,
    output logic [15:0] fill_data,
    output logic        i_done,
    output logic        d_done,
    output logic        d_wr_ack,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        mem_wr,
    output logic        mem_enable,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid,
    output logic        busy
);

    localparam int FILL_CYC = 8 + MEM_LAT;
    localparam int AGE_W    = $clog2(FILL_CYC + 1);
    localparam logic [AGE_W-1:0] FILL_CYC_W = AGE_W'(FILL_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFILL  = 2'd1,
        DFILL  = 2'd2,
        DWRITE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [11:0]       base_q, base_d;
    logic [2:0]        iss_cnt_q, iss_cnt_d;
    logic              iss_done_q, iss_done_d;
    logic [2:0]        rcv_cnt_q, rcv_cnt_d;
    logic [AGE_W-1:0]  age_q, age_d;
    logic [15:0]       wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;

    logic              mem_enable_q, mem_enable_d;
    logic              mem_wr_q, mem_wr_d;
    logic [15:0]       mem_addr_q, mem_addr_d;
    logic [15:0]       mem_data_in_q, mem_data_in_d;
    logic              i_grant_q, i_grant_d;
    logic              d_grant_q, d_grant_d;
    logic              d_wr_ack_q, d_wr_ack_d;
    logic              busy_q, busy_d;

    logic              grant_wr_s, grant_df_s, grant_if_s;
    logic              fill_valid_s, i_done_s, d_done_s;
    logic [2:0]        fill_word_s;
    logic [15:0]       fill_data_s;
    logic              unused_addr_bits_s;

    // Block offset bits never reach memory: fills always start at the block base.
    assign unused_addr_bits_s = ^{i_addr[3:0], d_addr[3:0]};

`ifdef MEM_ARB_RR_EN
    logic last_data_q, last_data_d;

    // Arbitration in IDLE: the class not served last wins a tie; write beats fill inside the data class.
    always_comb begin
        grant_wr_s  = 1'b0;
        grant_df_s  = 1'b0;
        grant_if_s  = 1'b0;
        last_data_d = last_data_q;
        if (state_q == IDLE) begin
            if ((d_wr_req || d_req) && (!i_req || !last_data_q)) begin
                if (d_wr_req) begin
                    grant_wr_s = 1'b1;
                end else begin
                    grant_df_s = 1'b1;
                end
                last_data_d = 1'b1;
            end else if (i_req) begin
                grant_if_s  = 1'b1;
                last_data_d = 1'b0;
            end else begin
                last_data_d = last_data_q;
            end
        end else begin
            last_data_d = last_data_q;
        end
    end

    // Last-served class flag; reset to instruction so data wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_data_q <= 1'b0;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`else
    // Arbitration in IDLE: fixed priority write > data fill > instruction fill.
    always_comb begin
        grant_wr_s = 1'b0;
        grant_df_s = 1'b0;
        grant_if_s = 1'b0;
        if (state_q == IDLE) begin
            if (d_wr_req) begin
                grant_wr_s = 1'b1;
            end else if (d_req) begin
                grant_df_s = 1'b1;
            end else if (i_req) begin
                grant_if_s = 1'b1;
            end else begin
                grant_wr_s = 1'b0;
            end
        end else begin
            grant_wr_s = 1'b0;
        end
    end
`endif

    // Transaction sequencing: next state, issue/receive counters and the return path.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        iss_cnt_d    = iss_cnt_q;
        iss_done_d   = iss_done_q;
        rcv_cnt_d    = rcv_cnt_q;
        age_d        = age_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        fill_valid_s = 1'b0;
        fill_word_s  = 3'd0;
        fill_data_s  = 16'h0000;
        i_done_s     = 1'b0;
        d_done_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_wr_s) begin
                    state_d   = DWRITE;
                    wr_addr_d = d_wr_addr;
                    wr_data_d = d_wr_data;
                end else if (grant_df_s || grant_if_s) begin
                    state_d    = grant_df_s ? DFILL : IFILL;
                    base_d     = grant_df_s ? d_addr[15:4] : i_addr[15:4];
                    iss_cnt_d  = 3'd0;
                    iss_done_d = 1'b0;
                    rcv_cnt_d  = 3'd0;
                    age_d      = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            IFILL, DFILL: begin
                if (!iss_done_q) begin
                    if (iss_cnt_q == 3'd7) begin
                        iss_done_d = 1'b1;
                    end else begin
                        iss_cnt_d = iss_cnt_q + 3'd1;
                    end
                end else begin
                    iss_cnt_d = iss_cnt_q;
                end
                if (age_q != FILL_CYC_W) begin
                    age_d = age_q + AGE_W'(1);
                end else begin
                    age_d = age_q;
                end
                // Returns are only meaningful inside this fill's own window.
                if (mem_data_valid && (age_q < FILL_CYC_W)) begin
                    fill_valid_s = 1'b1;
                    fill_word_s  = rcv_cnt_q;
                    fill_data_s  = mem_data_out;
                    rcv_cnt_d    = rcv_cnt_q + 3'd1;
                    if (rcv_cnt_q == 3'd7) begin
                        if (state_q == IFILL) begin
                            i_done_s = 1'b1;
                        end else begin
                            d_done_s = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    rcv_cnt_d = rcv_cnt_q;
                end
            end
            DWRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side and grant outputs are computed from the next state so they are registered.
    always_comb begin
        mem_enable_d  = 1'b0;
        mem_wr_d      = 1'b0;
        mem_addr_d    = 16'h0000;
        mem_data_in_d = 16'h0000;
        i_grant_d     = 1'b0;
        d_grant_d     = 1'b0;
        d_wr_ack_d    = 1'b0;
        busy_d        = (state_d != IDLE);
        case (state_d)
            IFILL, DFILL: begin
                mem_enable_d = !iss_done_d;
                mem_addr_d   = iss_done_d ? 16'h0000 : {base_d, iss_cnt_d, 1'b0};
                i_grant_d    = (state_d == IFILL);
                d_grant_d    = (state_d == DFILL);
            end
            DWRITE: begin
                mem_enable_d  = 1'b1;
                mem_wr_d      = 1'b1;
                mem_addr_d    = wr_addr_d;
                mem_data_in_d = wr_data_d;
                d_wr_ack_d    = 1'b1;
            end
            IDLE: begin
                mem_enable_d = 1'b0;
            end
            default: begin
                mem_enable_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; reset clears everything on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            base_q        <= 12'h000;
            iss_cnt_q     <= 3'd0;
            iss_done_q    <= 1'b0;
            rcv_cnt_q     <= 3'd0;
            age_q         <= '0;
            wr_addr_q     <= 16'h0000;
            wr_data_q     <= 16'h0000;
            mem_enable_q  <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= 16'h0000;
            mem_data_in_q <= 16'h0000;
            i_grant_q     <= 1'b0;
            d_grant_q     <= 1'b0;
            d_wr_ack_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            iss_cnt_q     <= iss_cnt_d;
            iss_done_q    <= iss_done_d;
            rcv_cnt_q     <= rcv_cnt_d;
            age_q         <= age_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            mem_enable_q  <= mem_enable_d;
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            i_grant_q     <= i_grant_d;
            d_grant_q     <= d_grant_d;
            d_wr_ack_q    <= d_wr_ack_d;
            busy_q        <= busy_d;
        end
    end

    assign mem_enable  = mem_enable_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;
    assign i_grant     = i_grant_q;
    assign d_grant     = d_grant_q;
    assign d_wr_ack    = d_wr_ack_q;
    assign busy        = busy_q;
    assign fill_valid  = fill_valid_s;
    assign fill_word   = fill_word_s;
    assign fill_data   = fill_data_s;
    assign i_done      = i_done_s;
    assign d_done      = d_done_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a latency-pipe memory model returns each read address as data.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr_req;
    logic [15:0] i_addr, d_addr, d_wr_addr, d_wr_data;
    logic        i_grant, d_grant, fill_valid, i_done, d_done, d_wr_ack;
    logic [2:0]  fill_word;
    logic [15:0] fill_data, mem_addr, mem_data_in, mem_data_out;
    logic        mem_wr, mem_enable, mem_data_valid, busy;

    mem_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .i_grant(i_grant), .d_grant(d_grant),
        .fill_valid(fill_valid), .fill_word(fill_word), .fill_data(fill_data),
        .i_done(i_done), .d_done(d_done), .d_wr_ack(d_wr_ack),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wr(mem_wr), .mem_enable(mem_enable),
        .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic wr; logic [15:0] addr; logic [15:0] data;} mem_exp_t;
    typedef struct packed {logic own; logic [2:0] word; logic [15:0] data;} fill_exp_t;

    mem_exp_t  exp_mem[$];
    fill_exp_t exp_fill[$];
    logic      exp_done[$];
    int        n_checks = 0;
    int        n_fail = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void miss(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT output with empty expectation queue", name);
    endfunction

    // own: 0 = instruction fill, 1 = data fill
    function automatic void push_fill(logic own, logic [15:0] base);
        for (int k = 0; k < 8; k++) begin
            exp_mem.push_back('{1'b0, base + 16'(2 * k), 16'h0000});
            exp_fill.push_back('{own, 3'(k), base + 16'(2 * k)});
        end
        exp_done.push_back(own);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (((exp_mem.size() != 0) || (exp_fill.size() != 0) || (exp_done.size() != 0) || (busy !== 1'b0)) && (t < 300)) begin
            tick();
            t++;
        end
        chk("drain_timeout", 32'(t < 300), 32'd1);
        tick();
        tick();
    endtask

    // Memory model: read issued in cycle c returns in cycle c+LAT with data = address.
    logic        pv[LAT];
    logic [15:0] pa[LAT];
    logic        iss_v;
    logic [15:0] iss_a;
    initial begin
        mem_data_valid = 1'b0;
        mem_data_out   = 16'h0000;
        for (int i = 0; i < LAT; i++) begin
            pv[i] = 1'b0;
            pa[i] = 16'h0000;
        end
        forever begin
            @(negedge clk);
            iss_v = (mem_enable === 1'b1) && (mem_wr === 1'b0);
            iss_a = mem_addr;
            @(posedge clk);
            #1;
            for (int i = LAT - 1; i > 0; i--) begin
                pv[i] = pv[i-1];
                pa[i] = pa[i-1];
            end
            pv[0] = iss_v;
            pa[0] = iss_a;
            mem_data_valid = pv[LAT-1];
            mem_data_out   = pv[LAT-1] ? pa[LAT-1] : 16'h0000;
        end
    end

    // Monitor: pops expectations whenever the DUT presents an issue, a fill word or a done pulse.
    int        gcnt;
    logic      prev_grant, prev_end, grant_now;
    mem_exp_t  me;
    fill_exp_t fe;
    logic      de;
    initial begin
        gcnt = 0;
        prev_grant = 1'b0;
        prev_end = 1'b0;
        forever begin
            @(negedge clk);
            grant_now = (i_grant === 1'b1) || (d_grant === 1'b1);
            if (grant_now) begin
                gcnt = prev_grant ? gcnt + 1 : 0;
                chk("issue_window", 32'(mem_enable), 32'(gcnt < 8));
            end
            if (prev_end) chk("idle_gap_busy", 32'(busy), 32'd0);
            if (mem_enable === 1'b1) begin
                if (exp_mem.size() == 0) miss("mem_issue");
                else begin
                    me = exp_mem.pop_front();
                    chk("mem_wr", 32'(mem_wr), 32'(me.wr));
                    chk("mem_addr", 32'(mem_addr), 32'(me.addr));
                    chk("d_wr_ack", 32'(d_wr_ack), 32'(me.wr));
                    if (me.wr) chk("mem_data_in", 32'(mem_data_in), 32'(me.data));
                end
            end
            if (fill_valid !== 1'b0) begin
                if (exp_fill.size() == 0) miss("fill_valid");
                else begin
                    fe = exp_fill.pop_front();
                    chk("fill_word", 32'(fill_word), 32'(fe.word));
                    chk("fill_data", 32'(fill_data), 32'(fe.data));
                    chk("fill_owner", 32'({i_grant, d_grant}), fe.own ? 32'd1 : 32'd2);
                end
            end
            if ((i_done !== 1'b0) || (d_done !== 1'b0)) begin
                if (exp_done.size() == 0) miss("done_pulse");
                else begin
                    de = exp_done.pop_front();
                    chk("done_kind", 32'({i_done, d_done}), de ? 32'd1 : 32'd2);
                    chk("fill_length", 32'(gcnt), 32'(8 + LAT - 1));
                end
            end
            prev_end   = (i_done === 1'b1) || (d_done === 1'b1) || (d_wr_ack === 1'b1);
            prev_grant = grant_now;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_wr_req = 1'b0;
        i_addr = 16'h0000; d_addr = 16'h0000; d_wr_addr = 16'h0000; d_wr_data = 16'h0000;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_ctrl", 32'({i_grant, d_grant, fill_valid, i_done, d_done, d_wr_ack, mem_wr, mem_enable, busy}), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_mem_data_in", 32'(mem_data_in), 32'd0);
        rst = 1'b0;
        tick();

        // Instruction fill from an unaligned address
        push_fill(1'b0, 16'h1230);
        i_addr = 16'h123A; i_req = 1'b1;
        tick();
        i_req = 1'b0;
        drain();

        // Request dropped at fill cycle 2, top-of-memory block
        push_fill(1'b0, 16'hFFF0);
        i_addr = 16'hFFFF; i_req = 1'b1;
        repeat (3) tick();
        i_req = 1'b0;
        drain();

        // Simultaneous write and data fill: write first, one IDLE cycle, then the fill
        exp_mem.push_back('{1'b1, 16'h0040, 16'hBEEF});
        push_fill(1'b1, 16'h0450);
        d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF; d_addr = 16'h0457;
        d_wr_req = 1'b1; d_req = 1'b1;
        tick();
        d_wr_req = 1'b0;
        tick();
        tick();
        d_req = 1'b0;
        drain();

        // Both fill classes held from reset across three arbitrations
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        push_fill(1'b1, 16'h3000);
`ifdef MEM_ARB_RR_EN
        push_fill(1'b0, 16'h2000);
`else
        push_fill(1'b1, 16'h3000);
`endif
        push_fill(1'b1, 16'h3000);
        i_addr = 16'h2004; d_addr = 16'h3008;
        i_req = 1'b1; d_req = 1'b1;
        tick();
        repeat (26) tick();
        i_req = 1'b0; d_req = 1'b0;
        drain();

        // Reset at fill cycle 5; stale returns later land in IDLE and DWRITE
        for (int k = 0; k < 6; k++) exp_mem.push_back('{1'b0, 16'h5A50 + 16'(2 * k), 16'h0000});
        exp_fill.push_back('{1'b0, 3'd0, 16'h5A50});
        exp_fill.push_back('{1'b0, 3'd1, 16'h5A52});
        i_addr = 16'h5A5A; i_req = 1'b1;
        tick();
        i_req = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midfill_reset_ctrl", 32'({i_grant, d_grant, fill_valid, i_done, d_done, d_wr_ack, mem_wr, mem_enable, busy}), 32'd0);
        chk("midfill_reset_addr", 32'(mem_addr), 32'd0);
        exp_mem.push_back('{1'b1, 16'h00FF, 16'h1234});
        d_wr_addr = 16'h00FF; d_wr_data = 16'h1234; d_wr_req = 1'b1;
        tick();
        d_wr_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stale_fill_valid", 32'(fill_valid), 32'd0);
            chk("stale_done", 32'({i_done, d_done}), 32'd0);
        end
        drain();

        chk("mem_queue_left", 32'(exp_mem.size()), 32'd0);
        chk("fill_queue_left", 32'(exp_fill.size()), 32'd0);
        chk("done_queue_left", 32'(exp_done.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
